// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbitration state and read-owner tag.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_CPU,
    ARB_IO_BURST
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_IO   = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating starvation counter: counts up on inc until LIMIT, clr has priority.
module arb_age_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  assign sat = (cnt_q == CntW'(LIMIT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU priority, aging override and locked peripheral bursts.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_wen,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_burst,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]       stat_cpu_stall_cycles,
  output logic [15:0]       stat_io_forced,
`endif
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned BurstW = $clog2(BURST_MAX + 1);

  arb_state_e      state_q;
  logic [BurstW-1:0] burst_cnt_q;
  logic [BurstW-1:0] burst_next;
  owner_e          rd_owner_q;

  logic cpu_gnt;
  logic starve_sat;
  logic starve_inc;
  logic starve_clr;
  logic burst_exit;

  always_comb begin
    cpu_gnt = 1'b0;
    io_gnt  = 1'b0;
    if (state_q == ARB_IO_BURST) begin
      io_gnt = io_req;
    end else begin
      cpu_gnt = cpu_req && !starve_sat;
      io_gnt  = io_req && !cpu_gnt;
    end
  end

  // burst_next counts the current grant, so the BURST_MAX-th grant is the last one.
  assign burst_next = burst_cnt_q + 1'b1;
  assign burst_exit = (state_q == ARB_IO_BURST) &&
                      (!io_req || !io_burst || (burst_next == BurstW'(BURST_MAX)));

  assign starve_inc = io_req && !io_gnt;
  assign starve_clr = io_gnt || !io_req || burst_exit;

  arb_age_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_age (
    .clock (clock),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_CPU;
      burst_cnt_q <= '0;
      rd_owner_q  <= OWN_NONE;
    end else begin
      unique case (state_q)
        ARB_CPU: begin
          if (io_gnt && io_burst && (BURST_MAX > 1)) begin
            state_q     <= ARB_IO_BURST;
            burst_cnt_q <= BurstW'(1);
          end
        end
        ARB_IO_BURST: begin
          if (burst_exit) begin
            state_q     <= ARB_CPU;
            burst_cnt_q <= '0;
          end else if (io_gnt) begin
            burst_cnt_q <= burst_next;
          end
        end
        default: begin
          state_q     <= ARB_CPU;
          burst_cnt_q <= '0;
        end
      endcase

      if (cpu_gnt && !cpu_wen) begin
        rd_owner_q <= OWN_CPU;
      end else if (io_gnt && !io_wen) begin
        rd_owner_q <= OWN_IO;
      end else begin
        rd_owner_q <= OWN_NONE;
      end
    end
  end

  assign cpu_stall  = cpu_req && !cpu_gnt;
  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign io_rvalid  = (rd_owner_q == OWN_IO);
  assign cpu_rdata  = ram_rdata;
  assign io_rdata   = ram_rdata;

  // Write enable is masked while reset is held so no stray write lands in RAM.
  always_comb begin
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_wen   = cpu_wen && !reset;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (io_gnt) begin
      ram_wen   = io_wen && !reset;
      ram_addr  = io_addr;
      ram_wdata = io_wdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_cpu_stall_cycles <= '0;
      stat_io_forced        <= '0;
    end else begin
      if (cpu_stall) begin
        stat_cpu_stall_cycles <= stat_cpu_stall_cycles + 1'b1;
      end
      if (io_gnt && (state_q == ARB_CPU) && cpu_req && starve_sat) begin
        stat_io_forced <= stat_io_forced + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural sync-read RAM.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wen;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        io_req, io_wen, io_burst;
  logic [11:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_gnt, io_rvalid;
  logic [31:0] io_rdata;
  logic        ram_wen;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_stall_cycles;
  logic [15:0] stat_io_forced;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .ADDR_W       (12),
    .DATA_W       (32),
    .STARVE_LIMIT (4),
    .BURST_MAX    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .io_req     (io_req),
    .io_wen     (io_wen),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_burst   (io_burst),
    .io_gnt     (io_gnt),
    .io_rvalid  (io_rvalid),
    .io_rdata   (io_rdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_cpu_stall_cycles (stat_cpu_stall_cycles),
    .stat_io_forced        (stat_io_forced),
`endif
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  logic [31:0] mem [4096];
  always @(posedge clock) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        cr, cw;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        ir, iw;
    logic [11:0] ia;
    logic [31:0] id;
    logic        ib;
    logic        e_stall, e_gnt, e_wen;
    logic [11:0] e_addr;
    logic        e_crv, e_irv;
    logic [31:0] e_data;
  } vec_t;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam int NumVec = 18;
  vec_t vt [NumVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cpu_req = v.cr; cpu_wen = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    io_req = v.ir; io_wen = v.iw; io_addr = v.ia; io_wdata = v.id; io_burst = v.ib;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_req = 1'b0; io_wen = 1'b0; io_addr = '0; io_wdata = '0; io_burst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int io_done;
    int guard;
    logic prev_gnt;

    // cr cw ca cd | ir iw ia id ib | stall gnt wen addr crv irv data
    vt[0]  = '{N,N,12'h000,32'h0,        N,N,12'h000,32'h0,N,        N,N,N,12'h000,N,N,32'h0};
    vt[1]  = '{Y,Y,12'h010,32'hDEADBEEF, N,N,12'h000,32'h0,N,        N,N,Y,12'h010,N,N,32'h0};
    vt[2]  = '{Y,N,12'h010,32'h0,        N,N,12'h000,32'h0,N,        N,N,N,12'h010,N,N,32'h0};
    vt[3]  = '{N,N,12'h000,32'h0,        N,N,12'h000,32'h0,N,        N,N,N,12'h000,Y,N,32'hDEADBEEF};
    vt[4]  = '{N,N,12'h000,32'h0,        Y,Y,12'h021,32'h12345678,N, N,Y,Y,12'h021,N,N,32'h0};
    vt[5]  = '{Y,Y,12'h020,32'hCAFEF00D, N,N,12'h000,32'h0,N,        N,N,Y,12'h020,N,N,32'h0};
    vt[6]  = '{Y,N,12'h020,32'h0,        N,N,12'h000,32'h0,N,        N,N,N,12'h020,N,N,32'h0};
    vt[7]  = '{N,N,12'h000,32'h0,        Y,N,12'h021,32'h0,N,        N,Y,N,12'h021,Y,N,32'hCAFEF00D};
    vt[8]  = '{Y,N,12'h020,32'h0,        N,N,12'h000,32'h0,N,        N,N,N,12'h020,N,Y,32'h12345678};
    vt[9]  = '{N,N,12'h000,32'h0,        Y,N,12'h021,32'h0,N,        N,Y,N,12'h021,Y,N,32'hCAFEF00D};
    vt[10] = '{N,N,12'h000,32'h0,        N,N,12'h000,32'h0,N,        N,N,N,12'h000,N,Y,32'h12345678};
    vt[11] = '{Y,N,12'h010,32'h0,        Y,N,12'h021,32'h0,N,        N,N,N,12'h010,N,N,32'h0};
    vt[12] = '{Y,N,12'h010,32'h0,        Y,N,12'h021,32'h0,N,        N,N,N,12'h010,Y,N,32'hDEADBEEF};
    vt[13] = vt[12];
    vt[14] = vt[12];
    vt[15] = '{Y,N,12'h010,32'h0,        Y,N,12'h021,32'h0,N,        Y,Y,N,12'h021,Y,N,32'hDEADBEEF};
    vt[16] = '{Y,N,12'h010,32'h0,        Y,N,12'h021,32'h0,N,        N,N,N,12'h010,N,Y,32'h12345678};
    vt[17] = '{N,N,12'h000,32'h0,        N,N,12'h000,32'h0,N,        N,N,N,12'h000,Y,N,32'hDEADBEEF};

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < NumVec; i++) begin
      drive(vt[i]);
      @(negedge clock);
      chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d io_gnt", i), 32'(io_gnt), 32'(vt[i].e_gnt));
      chk($sformatf("v%0d ram_wen", i), 32'(ram_wen), 32'(vt[i].e_wen));
      chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vt[i].e_crv));
      chk($sformatf("v%0d io_rvalid", i), 32'(io_rvalid), 32'(vt[i].e_irv));
      if (vt[i].e_crv) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vt[i].e_data);
      if (vt[i].e_irv) chk($sformatf("v%0d io_rdata", i), io_rdata, vt[i].e_data);
      next_cycle();
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stat_cpu_stall_cycles", stat_cpu_stall_cycles, 32'd1);
    chk("stat_io_forced", 32'(stat_io_forced), 32'd1);
`endif

    // Locked io burst against a continuously requesting CPU.
    cpu_req = 1'b1; cpu_addr = 12'h010;
    io_req = 1'b1; io_addr = 12'h021; io_burst = 1'b1;
    io_done = 0;
    prev_gnt = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clock);
      chk($sformatf("burst c%0d io_gnt", c), 32'(io_gnt), 32'((c >= 4) && (c <= 11)));
      chk($sformatf("burst c%0d cpu_stall", c), 32'(cpu_stall), 32'((c >= 4) && (c <= 11)));
      chk($sformatf("burst c%0d io_rvalid", c), 32'(io_rvalid), 32'(prev_gnt));
      if (io_rvalid) chk($sformatf("burst c%0d io_rdata", c), io_rdata, 32'h12345678);
      prev_gnt = io_gnt;
      if (io_gnt) io_done++;
      next_cycle();
    end
    guard = 0;
    while (io_done < 10 && guard < 40) begin
      @(negedge clock);
      if (io_gnt) io_done++;
      guard++;
      next_cycle();
    end
    chk("burst io reads done", 32'(io_done), 32'd10);
    idle();
    next_cycle();

    // Reset asserted in the middle of an io burst.
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 12'h030; cpu_wdata = 32'h5A5A5A5A;
    next_cycle();
    idle();
    io_req = 1'b1; io_addr = 12'h021; io_burst = 1'b1;
    repeat (3) next_cycle();
    io_wen = 1'b1; io_addr = 12'h030; io_wdata = 32'hBAD0BAD0;
    reset = 1'b1;
    @(negedge clock);
    chk("reset ram_wen", 32'(ram_wen), 32'd0);
    chk("reset cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("reset io_rvalid", 32'(io_rvalid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 12'h030;
    io_req = 1'b1; io_wen = 1'b0; io_addr = 12'h021; io_burst = 1'b0;
    #1;
    chk("post-reset cpu_stall", 32'(cpu_stall), 32'd0);
    chk("post-reset io_gnt", 32'(io_gnt), 32'd0);
    chk("post-reset ram_addr", 32'(ram_addr), 32'h030);
    next_cycle();
    idle();
    @(negedge clock);
    chk("post-reset cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("post-reset cpu_rdata", cpu_rdata, 32'h5A5A5A5A);
    chk("post-reset io_rvalid", 32'(io_rvalid), 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("post-reset stat_cpu_stall_cycles", stat_cpu_stall_cycles, 32'd0);
    chk("post-reset stat_io_forced", 32'(stat_io_forced), 32'd0);
`endif
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
